skill_a_ctrl: RTL and testbench

//  Upstream controller for the ball-teleport skill: turns a player key press into the skill

---
 rtl/skill_pkg.sv | 41 ++++
 rtl/key_edge_sync.sv | 44 ++++
 rtl/skill_a_ctrl.sv | 143 ++++++++++++++
 tb/tb_skill_a_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/skill_pkg.sv
//------------------------------------------------------------------------------
// Package  : skill_pkg
// Purpose  : Shared types and constants for the ball-teleport skill controller.
//            Skill state codes, court bounds, coordinate width, and the
//            coordinate clamp helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package skill_pkg;

  localparam int COORD_W = 11;

  // The teleport stage consumes these codes directly.
  typedef enum logic [3:0] {
    SK_IDLE = 4'd0,
    SK_REQ  = 4'd1,
    SK_LOAD = 4'd2,
    SK_COOL = 4'd3
  } sk_state_t;

  localparam logic signed [COORD_W-1:0] SK_X_MIN = 11'sd20;
  localparam logic signed [COORD_W-1:0] SK_X_MAX = 11'sd620;
  localparam logic signed [COORD_W-1:0] SK_Y_MIN = 11'sd20;
  localparam logic signed [COORD_W-1:0] SK_Y_MAX = 11'sd460;

  // Saturate a signed coordinate into [lo, hi]. All operands are COORD_W
  // signed, so the compares cannot wrap and negative values go to lo.
  function automatic logic signed [COORD_W-1:0] clamp_coord(
    input logic signed [COORD_W-1:0] v,
    input logic signed [COORD_W-1:0] lo,
    input logic signed [COORD_W-1:0] hi
  );
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_edge_sync.sv
//------------------------------------------------------------------------------
// Module   : key_edge_sync
// Purpose  : Two-flop synchronizer for an asynchronous key level, followed by
//            a registered rising-edge detector. The pulse appears three clocks
//            after the key edge.
// Ports    : clk     - system clock
//            rst     - asynchronous active-high reset
//            in_i    - raw asynchronous level
//            pulse_o - one-cycle pulse on a synchronized rising edge
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= in_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/skill_a_ctrl.sv
//------------------------------------------------------------------------------
// Module   : skill_a_ctrl
// Purpose  : Ball-teleport skill controller. Converts a key press into a
//            request to the teleport stage, captures and clamps the returned
//            coordinates, pulses a load to ball physics, then enforces a
//            cooldown before re-arming.
// Ports    : clk, rst               - clock, asynchronous active-high reset
//            skill_key              - raw key level (asynchronous)
//            in_play                - rally in progress
//            tp_valid, tp_ball_x/y  - teleport stage result
//            skill_state            - state code to the teleport stage
//            ball_load, ball_load_x/y - load pulse and clamped coordinates
//            skill_ready            - idle and accepting a press
//            tp_abort               - request aborted (timeout or rally end)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module skill_a_ctrl
  import skill_pkg::*;
#(
  parameter int                          COOLDOWN_CYCLES = 100_000_000,
  parameter int                          CNT_W           = 27,
  parameter int                          TP_TIMEOUT      = 16,
  parameter logic signed [COORD_W-1:0]   X_MIN           = SK_X_MIN,
  parameter logic signed [COORD_W-1:0]   X_MAX           = SK_X_MAX,
  parameter logic signed [COORD_W-1:0]   Y_MIN           = SK_Y_MIN,
  parameter logic signed [COORD_W-1:0]   Y_MAX           = SK_Y_MAX
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          skill_key,
  input  logic                          in_play,
  input  logic                          tp_valid,
  input  logic signed [COORD_W-1:0]     tp_ball_x,
  input  logic signed [COORD_W-1:0]     tp_ball_y,
  output logic [3:0]                    skill_state,
  output logic                          ball_load,
  output logic signed [COORD_W-1:0]     ball_load_x,
  output logic signed [COORD_W-1:0]     ball_load_y,
  output logic                          skill_ready,
  output logic                          tp_abort
);

  localparam int WAIT_W = $clog2(TP_TIMEOUT + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

  logic press;

  sk_state_t                    state_q;
  logic [WAIT_W-1:0]            wait_q;
  logic [CNT_W-1:0]             cool_q;
  logic                         ball_load_q;
  logic signed [COORD_W-1:0]    ball_x_q;
  logic signed [COORD_W-1:0]    ball_y_q;
  logic                         ready_q;
  logic                         abort_q;

  key_edge_sync u_key_sync (
    .clk     (clk),
    .rst     (rst),
    .in_i    (skill_key),
    .pulse_o (press)
  );

  // Single registered FSM. Pulse outputs default low every cycle and are
  // raised only on the transition that owns them, so each lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SK_IDLE;
      wait_q      <= '0;
      cool_q      <= '0;
      ball_load_q <= 1'b0;
      ball_x_q    <= '0;
      ball_y_q    <= '0;
      ready_q     <= 1'b1;
      abort_q     <= 1'b0;
    end else begin
      ball_load_q <= 1'b0;
      abort_q     <= 1'b0;
      case (state_q)
        SK_IDLE: begin
          // Presses outside a rally are dropped, not held.
          if (press && in_play) begin
            state_q <= SK_REQ;
            wait_q  <= '0;
            ready_q <= 1'b0;
          end
        end
        SK_REQ: begin
          if (!in_play) begin
            state_q <= SK_IDLE;
            abort_q <= 1'b1;
            ready_q <= 1'b1;
          end else if (tp_valid && (wait_q != '0)) begin
            // tp_valid in the first REQ cycle predates our request: the
            // teleport stage output lags skill_state by one register.
            state_q     <= SK_LOAD;
            ball_load_q <= 1'b1;
            ball_x_q    <= clamp_coord(tp_ball_x, X_MIN, X_MAX);
            ball_y_q    <= clamp_coord(tp_ball_y, Y_MIN, Y_MAX);
          end else if (wait_q == WAIT_LAST) begin
            // Timeout returns straight to IDLE with no cooldown.
            state_q <= SK_IDLE;
            abort_q <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        SK_LOAD: begin
          state_q <= SK_COOL;
          cool_q  <= '0;
        end
        SK_COOL: begin
          // Runs to completion regardless of in_play.
          if (cool_q == COOL_LAST) begin
            state_q <= SK_IDLE;
            ready_q <= 1'b1;
          end else begin
            cool_q <= cool_q + 1'b1;
          end
        end
        default: begin
          state_q <= SK_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign skill_state = state_q;
  assign ball_load   = ball_load_q;
  assign ball_load_x = ball_x_q;
  assign ball_load_y = ball_y_q;
  assign skill_ready = ready_q;
  assign tp_abort    = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_skill_a_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_skill_a_ctrl
// Purpose  : Directed self-checking bench for skill_a_ctrl with a short
//            cooldown (50 cycles) and a 16-cycle request timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_skill_a_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               skill_key;
  logic               in_play;
  logic               tp_valid;
  logic signed [10:0] tp_ball_x;
  logic signed [10:0] tp_ball_y;
  logic [3:0]         skill_state;
  logic               ball_load;
  logic signed [10:0] ball_load_x;
  logic signed [10:0] ball_load_y;
  logic               skill_ready;
  logic               tp_abort;

  int checks = 0;
  int errors = 0;
  int load_count = 0;
  int loads_before;

  skill_a_ctrl #(
    .COOLDOWN_CYCLES (50),
    .TP_TIMEOUT      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .skill_key   (skill_key),
    .in_play     (in_play),
    .tp_valid    (tp_valid),
    .tp_ball_x   (tp_ball_x),
    .tp_ball_y   (tp_ball_y),
    .skill_state (skill_state),
    .ball_load   (ball_load),
    .ball_load_x (ball_load_x),
    .ball_load_y (ball_load_y),
    .skill_ready (skill_ready),
    .tp_abort    (tp_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ball_load === 1'b1) load_count++;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Key rise -> REQ four clocks later.
  task automatic do_press(input string tag, input bit hold);
    skill_key = 1'b1;
    step(3);
    check({tag, "_pre_state"}, 32'(skill_state), 32'd0);
    step(1);
    check({tag, "_req_state"}, 32'(skill_state), 32'd1);
    check({tag, "_req_ready"}, 32'(skill_ready), 32'd0);
    if (!hold) skill_key = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_len);
    int n = 0;
    while (skill_ready !== 1'b1 && n < 200) begin
      n++;
      step(1);
    end
    check({tag, "_cool_len"}, 32'(n), 32'(exp_len));
    check({tag, "_idle_state"}, 32'(skill_state), 32'd0);
  endtask

  // Press, feed coords on the second REQ cycle, check the load, then cooldown.
  task automatic run_load(input string tag, input int x, input int y, input int ex, input int ey);
    do_press(tag, 1'b0);
    step(1);
    tp_valid  = 1'b1;
    tp_ball_x = 11'(x);
    tp_ball_y = 11'(y);
    loads_before = load_count;
    step(1);
    check({tag, "_load"},   32'(ball_load),   32'd1);
    check({tag, "_state2"}, 32'(skill_state), 32'd2);
    check({tag, "_x"},      32'(ball_load_x), 32'(ex));
    check({tag, "_y"},      32'(ball_load_y), 32'(ey));
    tp_valid  = 1'b0;
    tp_ball_x = '0;
    tp_ball_y = '0;
    step(1);
    check({tag, "_load_off"}, 32'(ball_load),   32'd0);
    check({tag, "_state3"},   32'(skill_state), 32'd3);
    check({tag, "_x_hold"},   32'(ball_load_x), 32'(ex));
    wait_ready(tag, 50);
    check({tag, "_one_load"}, 32'(load_count - loads_before), 32'd1);
  endtask

  initial begin
    rst = 1'b1; skill_key = 1'b0; in_play = 1'b0; tp_valid = 1'b0;
    tp_ball_x = '0; tp_ball_y = '0;
    step(2);
    check("rst_state", 32'(skill_state), 32'd0);
    check("rst_ready", 32'(skill_ready), 32'd1);
    check("rst_load",  32'(ball_load),   32'd0);
    check("rst_abort", 32'(tp_abort),    32'd0);
    check("rst_x",     32'(ball_load_x), 32'd0);
    rst = 1'b0;
    in_play = 1'b1;
    step(2);

    // 1: nominal request with in-range coordinates
    run_load("t1", 400, 250, 400, 250);

    // 2: clamping above/below the court
    run_load("t2a", 700, -5, 620, 20);
    run_load("t2b", 5, 500, 20, 460);

    // 3: teleport never answers -> timeout after 16 REQ cycles
    loads_before = load_count;
    do_press("t3", 1'b0);
    step(15);
    check("t3_still_req", 32'(skill_state), 32'd1);
    check("t3_no_abort",  32'(tp_abort),    32'd0);
    step(1);
    check("t3_abort",     32'(tp_abort),    32'd1);
    check("t3_idle",      32'(skill_state), 32'd0);
    check("t3_ready",     32'(skill_ready), 32'd1);
    step(1);
    check("t3_abort_off", 32'(tp_abort),    32'd0);
    check("t3_no_load",   32'(load_count - loads_before), 32'd0);
    do_press("t3_rearm", 1'b0);

    // 4: rally ends during REQ, then a press outside a rally
    in_play = 1'b0;
    step(1);
    check("t4_abort", 32'(tp_abort),    32'd1);
    check("t4_idle",  32'(skill_state), 32'd0);
    step(1);
    check("t4_abort_off", 32'(tp_abort), 32'd0);
    skill_key = 1'b1;
    step(6);
    check("t4_no_req", 32'(skill_state), 32'd0);
    skill_key = 1'b0;
    step(3);
    in_play = 1'b1;

    // 5: early tp_valid ignored; presses during COOL discarded; held key
    do_press("t5", 1'b1);
    tp_valid = 1'b1; tp_ball_x = 11'sd100; tp_ball_y = 11'sd100;
    step(1);
    check("t5_first_ignored", 32'(skill_state), 32'd1);
    check("t5_no_load_yet",   32'(ball_load),   32'd0);
    step(1);
    check("t5_load", 32'(ball_load),   32'd1);
    check("t5_x",    32'(ball_load_x), 32'd100);
    tp_valid = 1'b0;
    step(1);
    skill_key = 1'b0; step(3);
    skill_key = 1'b1; step(3);
    skill_key = 1'b0; step(3);
    skill_key = 1'b1;
    wait_ready("t5", 41);
    step(8);
    check("t5_held_no_req", 32'(skill_state), 32'd0);
    check("t5_held_ready",  32'(skill_ready), 32'd1);
    skill_key = 1'b0;
    step(3);
    do_press("t5_new", 1'b0);

    // 6a: asynchronous reset while in REQ
    #1 rst = 1'b1;
    #1;
    check("t6a_state", 32'(skill_state), 32'd0);
    check("t6a_ready", 32'(skill_ready), 32'd1);
    check("t6a_abort", 32'(tp_abort),    32'd0);
    step(1);
    rst = 1'b0;
    step(2);
    check("t6a_idle", 32'(skill_state), 32'd0);

    // 6b: asynchronous reset while in COOL
    do_press("t6b", 1'b0);
    step(1);
    tp_valid = 1'b1; tp_ball_x = 11'sd300; tp_ball_y = 11'sd200;
    step(1);
    tp_valid = 1'b0;
    step(5);
    check("t6b_in_cool", 32'(skill_state), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("t6b_state", 32'(skill_state), 32'd0);
    check("t6b_ready", 32'(skill_ready), 32'd1);
    check("t6b_x",     32'(ball_load_x), 32'd0);
    check("t6b_y",     32'(ball_load_y), 32'd0);
    step(1);
    rst = 1'b0;
    loads_before = load_count;
    step(60);
    check("t6b_idle",    32'(skill_state), 32'd0);
    check("t6b_no_load", 32'(load_count - loads_before), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
